flash_cycle_timer: RTL and testbench

Bus-cycle timing stage directly downstream of the flash address decoder in the relocator CPLD. It takes the decoded flash-select qualifier, samples the 68000 strobes on MB_CLK, and generates correctly timed per-byte-lane FLASH_RD / FLASH_WR strobes to the two flash devices. It also generates the local /DTACK that terminates flash cycles, because /AS is withheld from the motherboard during those cycles. One access is handled at a time; the block is idle between CPU bus cycles.

---
 rtl/flash_cycle_timer.sv | 206 ++++++++++++++++++++
 tb/tb_flash_cycle_timer.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/flash_cycle_timer.sv
// flash_cycle_timer
// Bus-cycle timing stage behind the flash address decoder. It samples the
// 68000 strobes on MB_CLK and drives per-lane FLASH_RD / FLASH_WR strobes to
// the two flash devices. Because /AS is withheld from the motherboard during
// flash cycles, it also drives the local /DTACK that ends those cycles.
// Only one access is in flight at a time.
// Optional build macro: FLASH_WR_LOCK_EN. When it is defined, writes accepted
// while WR_UNLOCK=0 still run and are acknowledged, but never pulse FLASH_WR.
module flash_cycle_timer #(
  parameter int unsigned RD_WAIT  = 3,
  parameter int unsigned WR_SETUP = 1,
  parameter int unsigned WR_PULSE = 3,
  parameter int unsigned RECOVERY = 1
) (
  input  logic       MB_CLK,
  input  logic       RESET,
  input  logic       FLASH_SEL,
  input  logic       CPU_AS,
  input  logic       RW,
  input  logic       UDS,
  input  logic       LDS,
  input  logic       WR_UNLOCK,
  output logic [1:0] FLASH_RD,
  output logic [1:0] FLASH_WR,
  output logic       CPU_DTACK,
  output logic       DTACK_OE,
  output logic       BUSY
);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SETUP   = 3'd1,
    ST_STROBE  = 3'd2,
    ST_ACK     = 3'd3,
    ST_RECOVER = 3'd4
  } state_e;

  // A cycle count of zero would never expire, so it is promoted to one.
  function automatic logic [3:0] load_value(input int unsigned cycles);
    if (cycles == 32'd0) begin
      return 4'd1;
    end else begin
      return 4'(cycles);
    end
  endfunction

  localparam logic [3:0] RD_WAIT_C  = load_value(RD_WAIT);
  localparam logic [3:0] WR_SETUP_C = load_value(WR_SETUP);
  localparam logic [3:0] WR_PULSE_C = load_value(WR_PULSE);
  localparam logic [3:0] RECOVERY_C = load_value(RECOVERY);

  state_e     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [1:0] lanes_q, lanes_d;
  logic       rw_q, rw_d;
  logic       wr_en_q, wr_en_d;

  logic [1:0] flash_rd_q, flash_rd_d;
  logic [1:0] flash_wr_q, flash_wr_d;
  logic       dtack_q, dtack_d;
  logic       busy_q, busy_d;

  logic       unlock_s;
  logic       request_s;
  logic       expired_s;

`ifdef FLASH_WR_LOCK_EN
  assign unlock_s = WR_UNLOCK;
`else
  logic unused_wr_unlock_s;
  assign unused_wr_unlock_s = WR_UNLOCK;
  assign unlock_s           = 1'b1;
`endif

  assign request_s = FLASH_SEL && !CPU_AS && (!UDS || !LDS);
  // Counter expires on one; anything at or below one counts as expired.
  assign expired_s = (cnt_q <= 4'd1);

  // Next-state logic, then registered output values derived from the next state.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    lanes_d = lanes_q;
    rw_d    = rw_q;
    wr_en_d = wr_en_q;

    case (state_q)
      ST_IDLE: begin
        if (request_s) begin
          lanes_d = {UDS, LDS};
          rw_d    = RW;
          wr_en_d = unlock_s;
          if (RW) begin
            state_d = ST_STROBE;
            cnt_d   = RD_WAIT_C;
          end else begin
            state_d = ST_SETUP;
            cnt_d   = WR_SETUP_C;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SETUP: begin
        if (CPU_AS) begin
          state_d = ST_RECOVER;
          cnt_d   = RECOVERY_C;
        end else if (expired_s) begin
          state_d = ST_STROBE;
          cnt_d   = WR_PULSE_C;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_STROBE: begin
        if (CPU_AS) begin
          state_d = ST_RECOVER;
          cnt_d   = RECOVERY_C;
        end else if (expired_s) begin
          state_d = ST_ACK;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_ACK: begin
        if (CPU_AS) begin
          state_d = ST_RECOVER;
          cnt_d   = RECOVERY_C;
        end else begin
          state_d = ST_ACK;
        end
      end
      ST_RECOVER: begin
        if (expired_s) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = 4'd1;
      end
    endcase

    flash_rd_d = 2'b11;
    flash_wr_d = 2'b11;
    dtack_d    = 1'b1;
    busy_d     = (state_d != ST_IDLE);

    case (state_d)
      ST_STROBE: begin
        if (rw_d) begin
          flash_rd_d = lanes_d;
        end else if (wr_en_d) begin
          flash_wr_d = lanes_d;
        end else begin
          flash_wr_d = 2'b11;
        end
      end
      ST_ACK: begin
        dtack_d = 1'b0;
        if (rw_d) begin
          flash_rd_d = lanes_d;
        end else begin
          flash_rd_d = 2'b11;
        end
      end
      default: begin
        flash_rd_d = 2'b11;
      end
    endcase
  end

  // State, access context and output registers with synchronous reset.
  always_ff @(posedge MB_CLK) begin
    if (RESET) begin
      state_q    <= ST_IDLE;
      cnt_q      <= 4'd1;
      lanes_q    <= 2'b11;
      rw_q       <= 1'b1;
      wr_en_q    <= 1'b0;
      flash_rd_q <= 2'b11;
      flash_wr_q <= 2'b11;
      dtack_q    <= 1'b1;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      lanes_q    <= lanes_d;
      rw_q       <= rw_d;
      wr_en_q    <= wr_en_d;
      flash_rd_q <= flash_rd_d;
      flash_wr_q <= flash_wr_d;
      dtack_q    <= dtack_d;
      busy_q     <= busy_d;
    end
  end

  assign FLASH_RD  = flash_rd_q;
  assign FLASH_WR  = flash_wr_q;
  assign CPU_DTACK = dtack_q;
  assign DTACK_OE  = busy_q;
  assign BUSY      = busy_q;

endmodule

// File: tb/tb_flash_cycle_timer.sv
// Testbench for flash_cycle_timer: two instances (default timing, and
// RD_WAIT=0 / RECOVERY=15) checked cycle by cycle against a timeline model
// that derives every output from the edge offset relative to the accept edge.
module tb_flash_cycle_timer;

  localparam int D2_RD_WAIT  = 0;
  localparam int D2_RECOVERY = 15;
`ifdef FLASH_WR_LOCK_EN
  localparam bit LOCK_EN = 1'b1;
`else
  localparam bit LOCK_EN = 1'b0;
`endif

  logic       MB_CLK = 1'b0;
  logic       RESET, FLASH_SEL, FLASH_SEL2, CPU_AS, RW, UDS, LDS, WR_UNLOCK;
  logic [1:0] rd0, wr0, rd1, wr1;
  logic       dtack0, oe0, busy0, dtack1, oe1, busy1;
  int         checks = 0;
  int         passed = 0;

  always #5 MB_CLK = ~MB_CLK;

  flash_cycle_timer dut (
    .MB_CLK(MB_CLK), .RESET(RESET), .FLASH_SEL(FLASH_SEL), .CPU_AS(CPU_AS),
    .RW(RW), .UDS(UDS), .LDS(LDS), .WR_UNLOCK(WR_UNLOCK),
    .FLASH_RD(rd0), .FLASH_WR(wr0), .CPU_DTACK(dtack0), .DTACK_OE(oe0), .BUSY(busy0)
  );

  flash_cycle_timer #(.RD_WAIT(D2_RD_WAIT), .RECOVERY(D2_RECOVERY)) dut2 (
    .MB_CLK(MB_CLK), .RESET(RESET), .FLASH_SEL(FLASH_SEL2), .CPU_AS(CPU_AS),
    .RW(RW), .UDS(UDS), .LDS(LDS), .WR_UNLOCK(WR_UNLOCK),
    .FLASH_RD(rd1), .FLASH_WR(wr1), .CPU_DTACK(dtack1), .DTACK_OE(oe1), .BUSY(busy1)
  );

  task automatic step();
    @(posedge MB_CLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [1:0] obs, input logic [1:0] expv);
    checks++;
    assert (obs === expv) passed++;
    else $error("FAIL %s: observed %b expected %b", tag, obs, expv);
  endtask

  task automatic expect_cycle(input bit which, input string tag, input int t,
                              input logic [1:0] rd, input logic [1:0] wr,
                              input logic dtack, input logic busy);
    logic [1:0] ord, owr;
    logic       odt, ooe, obz;
    if (which) begin
      ord = rd1; owr = wr1; odt = dtack1; ooe = oe1; obz = busy1;
    end else begin
      ord = rd0; owr = wr0; odt = dtack0; ooe = oe0; obz = busy0;
    end
    check($sformatf("%s[u%0d t=%0d] FLASH_RD", tag, which, t), ord, rd);
    check($sformatf("%s[u%0d t=%0d] FLASH_WR", tag, which, t), owr, wr);
    check($sformatf("%s[u%0d t=%0d] CPU_DTACK", tag, which, t), {1'b0, odt}, {1'b0, dtack});
    check($sformatf("%s[u%0d t=%0d] DTACK_OE", tag, which, t), {1'b0, ooe}, {1'b0, busy});
    check($sformatf("%s[u%0d t=%0d] BUSY", tag, which, t), {1'b0, obz}, {1'b0, busy});
  endtask

  // Timeline model: t = edges since accept, k = edge offset where /AS=1 is sampled.
  function automatic void model(input int rdw, input int ws, input int wp, input int rec,
                                input bit rw, input logic [1:0] lanes, input bit wr_on,
                                input int k, input int t,
                                output logic [1:0] rd, output logic [1:0] wr,
                                output logic dtack, output logic busy);
    rd    = 2'b11;
    wr    = 2'b11;
    dtack = 1'b1;
    busy  = (t < k + rec);
    if (t < k) begin
      if (rw) begin
        rd = lanes;
        if (t >= rdw) dtack = 1'b0;
      end else begin
        if (wr_on && t >= ws && t < ws + wp) wr = lanes;
        if (t >= ws + wp) dtack = 1'b0;
      end
    end
  endfunction

  task automatic set_idle_inputs();
    FLASH_SEL = 1'b0; FLASH_SEL2 = 1'b0; CPU_AS = 1'b1;
    RW = 1'b1; UDS = 1'b1; LDS = 1'b1; WR_UNLOCK = 1'b0;
  endtask

  // One complete access on unit `which`; with b2b a word read request is
  // re-asserted during recovery so the next access call is the accept edge.
  task automatic access(input string tag, input bit which, input bit rw,
                        input logic [1:0] lanes, input bit unlock, input int k, input bit b2b);
    int rdw, ws, wp, rec;
    bit wr_on;
    logic [1:0] erd, ewr, rnd;
    logic edt, ebz;
    rdw = which ? ((D2_RD_WAIT == 0) ? 1 : D2_RD_WAIT) : 3;
    ws  = 1;
    wp  = 3;
    rec = which ? ((D2_RECOVERY == 0) ? 1 : D2_RECOVERY) : 1;
    wr_on = unlock || !LOCK_EN;
    FLASH_SEL = !which; FLASH_SEL2 = which;
    CPU_AS = 1'b0; RW = rw; UDS = lanes[1]; LDS = lanes[0]; WR_UNLOCK = unlock;
    for (int t = 0; t <= k + rec; t++) begin
      if (t > 0) begin
        CPU_AS = (t >= k);
        if (b2b && t > k) begin
          CPU_AS = 1'b0; UDS = 1'b0; LDS = 1'b0; RW = 1'b1;
        end else begin
          rnd = 2'($urandom_range(0, 3));
          UDS = rnd[1]; LDS = rnd[0];
          RW = 1'($urandom); WR_UNLOCK = 1'($urandom);
        end
      end
      step();
      model(rdw, ws, wp, rec, rw, lanes, wr_on, k, t, erd, ewr, edt, ebz);
      expect_cycle(which, tag, t, erd, ewr, edt, ebz);
    end
    if (!b2b) set_idle_inputs();
  endtask

  // Idle cycles with inputs that must not start an access on either unit.
  task automatic idle_cycles(input int n);
    int mode;
    for (int i = 0; i < n; i++) begin
      mode = int'($urandom_range(0, 2));
      case (mode)
        0: begin FLASH_SEL = 1'b0; FLASH_SEL2 = 1'b0; CPU_AS = 1'b0; UDS = 1'b0; LDS = 1'b0; end
        1: begin FLASH_SEL = 1'b1; FLASH_SEL2 = 1'b1; CPU_AS = 1'b1; UDS = 1'b0; LDS = 1'b0; end
        default: begin FLASH_SEL = 1'b1; FLASH_SEL2 = 1'b1; CPU_AS = 1'b0; UDS = 1'b1; LDS = 1'b1; end
      endcase
      step();
      expect_cycle(1'b0, "idle", i, 2'b11, 2'b11, 1'b1, 1'b0);
      expect_cycle(1'b1, "idle", i, 2'b11, 2'b11, 1'b1, 1'b0);
    end
    set_idle_inputs();
  endtask

  initial begin
    logic [1:0] ln;
    int k;
    bit w, r, u;
    RESET = 1'b1;
    set_idle_inputs();
    step();
    expect_cycle(1'b0, "reset", 0, 2'b11, 2'b11, 1'b1, 1'b0);
    expect_cycle(1'b1, "reset", 0, 2'b11, 2'b11, 1'b1, 1'b0);
    RESET = 1'b0;
    idle_cycles(2);

    // Directed cases
    access("word_read", 1'b0, 1'b1, 2'b00, 1'b0, 5, 1'b0);
    idle_cycles(1);
    access("lower_write", 1'b0, 1'b0, 2'b10, 1'b0, 6, 1'b0);
    access("upper_read", 1'b0, 1'b1, 2'b01, 1'b0, 4, 1'b0);
    access("abort_read", 1'b0, 1'b1, 2'b00, 1'b0, 1, 1'b0);
    access("abort_rd_exp", 1'b0, 1'b1, 2'b00, 1'b0, 3, 1'b0);
    access("abort_wr_setup", 1'b0, 1'b0, 2'b00, 1'b1, 1, 1'b0);
    access("abort_wr_strobe", 1'b0, 1'b0, 2'b01, 1'b1, 3, 1'b0);
    access("locked_write", 1'b0, 1'b0, 2'b00, 1'b0, 6, 1'b0);
    access("unlocked_write", 1'b0, 1'b0, 2'b00, 1'b1, 6, 1'b0);

    // Reset in the middle of a read strobe
    FLASH_SEL = 1'b1; CPU_AS = 1'b0; RW = 1'b1; UDS = 1'b0; LDS = 1'b0;
    step();
    expect_cycle(1'b0, "rst_mid", 0, 2'b00, 2'b11, 1'b1, 1'b1);
    step();
    expect_cycle(1'b0, "rst_mid", 1, 2'b00, 2'b11, 1'b1, 1'b1);
    RESET = 1'b1;
    step();
    expect_cycle(1'b0, "rst_mid", 2, 2'b11, 2'b11, 1'b1, 1'b0);
    RESET = 1'b0;
    set_idle_inputs();
    step();
    expect_cycle(1'b0, "rst_mid", 3, 2'b11, 2'b11, 1'b1, 1'b0);
    access("after_reset", 1'b0, 1'b1, 2'b00, 1'b0, 5, 1'b0);

    // Zero wait promoted to one, long recovery with a request held pending
    access("rdw0_b2b", 1'b1, 1'b1, 2'b00, 1'b0, 3, 1'b1);
    access("after_recov", 1'b1, 1'b1, 2'b00, 1'b0, 2, 1'b0);
    access("u2_write", 1'b1, 1'b0, 2'b10, 1'b1, 5, 1'b0);

    // Randomized accesses
    for (int i = 0; i < 40; i++) begin
      idle_cycles(int'($urandom_range(0, 3)));
      w  = 1'($urandom_range(0, 3) == 0);
      r  = 1'($urandom);
      u  = 1'($urandom);
      ln = 2'($urandom_range(0, 2));
      k  = int'($urandom_range(1, 12));
      access("random", w, r, ln, u, k, 1'b0);
    end
    idle_cycles(1);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
